// File: rtl/serial_adder_control.sv
// Push-button controlled bit-serial adder: synchronizes LoadB/Run, loads B,
// captures A on Run and adds A+B one bit per cycle, publishing Sum/CO once.
module serial_adder_control #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             loadb_i,
  input  logic             run_i,
  input  logic [WIDTH-1:0] sw_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             co_o,
  output logic [WIDTH-1:0] aval_o,
  output logic [WIDTH-1:0] bval_o,
  output logic             busy_o
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        run_sync_q, loadb_sync_q;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              carry_q, carry_d;
  logic              co_q, co_d;
  logic              busy_q, busy_d;
  logic [CW-1:0]     count_q, count_d;
  logic              run_s_c, loadb_s_c;
  logic              sum_bit_c, cout_c;

  // Buttons are active-low; synchronizers preset to "released"
  assign run_s_c   = ~run_sync_q[1];
  assign loadb_s_c = ~loadb_sync_q[1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      run_sync_q   <= 2'b11;
      loadb_sync_q <= 2'b11;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      sum_q        <= '0;
      carry_q      <= 1'b0;
      co_q         <= 1'b0;
      busy_q       <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      run_sync_q   <= {run_sync_q[0], run_i};
      loadb_sync_q <= {loadb_sync_q[0], loadb_i};
      a_q          <= a_d;
      b_q          <= b_d;
      res_q        <= res_d;
      sum_q        <= sum_d;
      carry_q      <= carry_d;
      co_q         <= co_d;
      busy_q       <= busy_d;
      count_q      <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    co_d      = co_q;
    busy_d    = busy_q;
    count_d   = count_q;
    sum_bit_c = a_q[count_q] ^ b_q[count_q] ^ carry_q;
    cout_c    = (a_q[count_q] & b_q[count_q]) | (carry_q & (a_q[count_q] ^ b_q[count_q]));

    case (state_q)
      S_IDLE: begin
        // Run takes priority over LoadB on the same edge
        if (run_s_c) begin
          a_d     = sw_i;
          carry_d = 1'b0;
          count_d = '0;
          res_d   = '0;
          busy_d  = 1'b1;
          state_d = S_ADD;
        end else if (loadb_s_c) begin
          b_d = sw_i;
        end
      end
      S_ADD: begin
        res_d   = {sum_bit_c, res_q[WIDTH-1:1]};
        carry_d = cout_c;
        if (count_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      S_DONE: begin
        sum_d   = res_q;
        co_d    = carry_q;
        busy_d  = 1'b0;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        // Wait for Run release so a held button yields a single add
        if (loadb_s_c) begin
          b_d = sw_i;
        end
        if (!run_s_c) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign sum_o  = sum_q;
  assign co_o   = co_q;
  assign aval_o = a_q;
  assign bval_o = b_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_serial_adder_control.sv
// Randomized self-checking bench for serial_adder_control against a
// transaction-level arithmetic model of the operator interface.
module tb_serial_adder_control;

  localparam int unsigned W = 16;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         loadb_i = 1'b1;
  logic         run_i = 1'b1;
  logic [W-1:0] sw_i = '0;
  logic [W-1:0] sum_o, aval_o, bval_o;
  logic         co_o, busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] ma, mb, msum;
  logic         mco;

  serial_adder_control #(.WIDTH(W)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .loadb_i(loadb_i),
    .run_i  (run_i),
    .sw_i   (sw_i),
    .sum_o  (sum_o),
    .co_o   (co_o),
    .aval_o (aval_o),
    .bval_o (bval_o),
    .busy_o (busy_o)
  );

  always #10 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic model_add();
    logic [W:0] full;
    full = {1'b0, ma} + {1'b0, mb};
    msum = full[W-1:0];
    mco  = full[W];
  endtask

  task automatic load_b(input logic [W-1:0] v);
    sw_i = v;
    loadb_i = 1'b0;
    repeat (3) tick();
    chk("bval_load", 32'(bval_o), 32'(v));
    loadb_i = 1'b1;
    repeat (3) tick();
    mb = v;
  endtask

  task automatic wait_busy_rise(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!busy_o && lat < 12);
  endtask

  // Counts busy cycles; flags any Sum/CO change before the final cycle
  task automatic wait_busy_fall(output int n, output bit partial);
    logic [W-1:0] s0;
    logic         c0;
    s0 = sum_o;
    c0 = co_o;
    n = 1;
    partial = 1'b0;
    while (busy_o && n < 40) begin
      if (sum_o !== s0 || co_o !== c0) partial = 1'b1;
      tick();
      if (busy_o) n++;
    end
  endtask

  task automatic run_add(input logic [W-1:0] a, input bit rel);
    int lat, n;
    bit partial;
    sw_i = a;
    run_i = 1'b0;
    wait_busy_rise(lat);
    chk("run_latency", 32'(lat), 32'd3);
    chk("aval_capture", 32'(aval_o), 32'(a));
    ma = a;
    wait_busy_fall(n, partial);
    chk("busy_cycles", 32'(n), 32'd17);
    chk("no_partial", 32'(partial), 32'd0);
    model_add();
    chk("sum", 32'(sum_o), 32'(msum));
    chk("co", 32'(co_o), 32'(mco));
    if (rel) begin
      run_i = 1'b1;
      repeat (4) tick();
    end
  endtask

  initial begin
    int lat, n, extra;
    bit partial;
    ma = '0; mb = '0; msum = '0; mco = 1'b0;
    repeat (3) tick();
    chk("rst_sum", 32'(sum_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_bval", 32'(bval_o), 32'd0);
    rst_i = 1'b0;
    repeat (2) tick();

    // Basic add
    load_b(16'h0001);
    run_add(16'h0002, 1'b1);
    chk("basic_sum", 32'(sum_o), 32'h0003);

    // Carry boundaries
    load_b(16'hFFFF); run_add(16'h0001, 1'b1);
    load_b(16'h8000); run_add(16'h8000, 1'b1);
    load_b(16'h7FFF); run_add(16'h7FFF, 1'b1);
    chk("max_pos_sum", 32'(sum_o), 32'hFFFE);

    // Random operands
    for (int i = 0; i < 12; i++) begin
      load_b(W'($urandom));
      run_add(W'($urandom), 1'b1);
    end

    // Held Run produces a single add; B change while held does not re-add
    load_b(16'h0005);
    run_add(16'h0003, 1'b0);
    extra = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (busy_o) extra++;
    end
    chk("held_no_readd", 32'(extra), 32'd0);
    chk("held_sum", 32'(sum_o), 32'h0008);
    load_b(16'h0001);
    repeat (20) tick();
    chk("held_sum_after_b", 32'(sum_o), 32'h0008);
    run_i = 1'b1;
    repeat (4) tick();
    run_add(16'h0003, 1'b1);
    chk("readd_sum", 32'(sum_o), 32'h0004);

    // LoadB ignored during ADD, honoured in HOLD
    load_b(16'h00F0);
    sw_i = 16'h000F;
    run_i = 1'b0;
    wait_busy_rise(lat);
    ma = 16'h000F;
    sw_i = 16'h1234;
    loadb_i = 1'b0;
    repeat (3) tick();
    loadb_i = 1'b1;
    repeat (3) tick();
    chk("add_bval_stable", 32'(bval_o), 32'h00F0);
    chk("add_aval_stable", 32'(aval_o), 32'h000F);
    wait_busy_fall(n, partial);
    model_add();
    chk("add_old_b_sum", 32'(sum_o), 32'(msum));
    load_b(16'h1234);
    chk("hold_sum_kept", 32'(sum_o), 32'(msum));
    run_i = 1'b1;
    repeat (4) tick();

    // Reset in the middle of an add
    load_b(16'h0101);
    sw_i = 16'h1111;
    run_i = 1'b0;
    wait_busy_rise(lat);
    repeat (8) tick();
    run_i = 1'b1;
    rst_i = 1'b1;
    #1;
    chk("midrst_sum", 32'(sum_o), 32'd0);
    chk("midrst_co", 32'(co_o), 32'd0);
    chk("midrst_aval", 32'(aval_o), 32'd0);
    chk("midrst_bval", 32'(bval_o), 32'd0);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    ma = '0; mb = '0; msum = '0; mco = 1'b0;
    repeat (2) tick();
    rst_i = 1'b0;
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (busy_o) extra++;
    end
    chk("post_rst_idle", 32'(extra), 32'd0);
    chk("post_rst_sum", 32'(sum_o), 32'd0);

    // Run and LoadB on the same edge: Run wins
    load_b(16'h0001);
    sw_i = 16'h0010;
    run_i = 1'b0;
    loadb_i = 1'b0;
    wait_busy_rise(lat);
    loadb_i = 1'b1;
    chk("both_latency", 32'(lat), 32'd3);
    chk("both_bval", 32'(bval_o), 32'h0001);
    chk("both_aval", 32'(aval_o), 32'h0010);
    ma = 16'h0010;
    wait_busy_fall(n, partial);
    model_add();
    chk("both_sum", 32'(sum_o), 32'h0011);
    chk("both_bval_end", 32'(bval_o), 32'h0001);
    run_i = 1'b1;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
